// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the architectural PC and turns decode's PC-select
// decision into one-at-a-time instruction-memory fetches. Each returned
// word is held in an output register until decode takes it. A taken
// redirect kills any in-flight request and restarts fetch at the target.
//
// Optional build macro PC_FETCH_MISALIGN_TRAP_EN: when defined, a redirect
// target whose low two bits are non-zero is taken as-is, raises the sticky
// fetch_misaligned flag and halts fetch until reset. When undefined, the
// target is word-aligned and fetch_misaligned is tied low.
module pc_fetch_unit #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic              pc_input_sel,
    input  logic [XLEN-1:0]   alu_result,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [XLEN-1:0]   imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [XLEN-1:0]   if_instr,
    output logic [XLEN-1:0]   if_pc,
    output logic              fetch_misaligned
);

    localparam logic PC_INPUT_PC_PLUS_4 = 1'b0;
    localparam logic PC_INPUT_ALU       = 1'b1;

    typedef enum logic {
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              kill;
    logic              kill_next;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   req_pc;
    logic [XLEN-1:0]   target;
    logic              redirect_taken;
    logic              req_accept;
    logic              rsp_fill;
    logic              fetch_halt;

    // A PC_PLUS_4 selection is just the normal sequential path, so only the
    // ALU selection counts as a redirect.
    assign redirect_taken = redirect_valid && (pc_input_sel == PC_INPUT_ALU);
    assign req_accept     = imem_req_valid && imem_req_ready;

    // A response only reaches decode if it was not killed earlier and is
    // not being overtaken by a redirect in the very cycle it arrives.
    assign rsp_fill = (state == ST_WAIT) && imem_rsp_valid && !kill && !redirect_taken;

`ifdef PC_FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    assign target           = alu_result;
    assign fetch_halt       = misaligned_q;
    assign fetch_misaligned = misaligned_q;

    // Sticky trap flag: once a misaligned target is seen, only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned_q <= 1'b0;
        end else if (redirect_taken && (alu_result[1:0] != 2'b00)) begin
            misaligned_q <= 1'b1;
        end
    end
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    assign target           = alu_result & ALIGN_MASK;
    assign fetch_halt       = 1'b0;
    assign fetch_misaligned = 1'b0;
`endif

    // State register for the request/wait handshake, plus the kill flag
    // that marks the outstanding response as stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_REQ;
            kill  <= 1'b0;
        end else begin
            state <= state_next;
            kill  <= kill_next;
        end
    end

    // Next-state logic: one request outstanding at a time; a redirect while
    // a request is in flight (or being accepted now) poisons its response.
    always_comb begin
        state_next = state;
        kill_next  = kill;
        case (state)
            ST_REQ: begin
                if (req_accept) begin
                    state_next = ST_WAIT;
                    kill_next  = redirect_taken;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = ST_REQ;
                    kill_next  = 1'b0;
                end else if (redirect_taken) begin
                    kill_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_REQ;
                kill_next  = 1'b0;
            end
        endcase
    end

    // Output logic: request only when the output register has room (empty or
    // draining this cycle), never during reset or after a misalignment trap.
    always_comb begin
        imem_req_valid = !reset && (state == ST_REQ) && (!if_valid || if_ready) && !fetch_halt;
        imem_req_addr  = pc;
    end

    // PC and request-address tracking; a redirect wins over the +4 step.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            if (req_accept) begin
                req_pc <= pc;
            end
            if (redirect_taken) begin
                pc <= target;
            end else if (req_accept) begin
                pc <= pc + XLEN'(4);
            end
        end
    end

    // Decode-facing output register: holds under backpressure, invalidated
    // by a redirect, refilled by a live response, cleared when consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (redirect_taken) begin
            if_valid <= 1'b0;
        end else if (rsp_fill) begin
            if_valid <= 1'b1;
            if_instr <= imem_rsp_data;
            if_pc    <= req_pc;
        end else if (if_valid && if_ready) begin
            if_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed, table-driven bench for pc_fetch_unit.
// Each table row is one clock cycle of stimulus plus the outputs expected
// in that cycle. A small memory model answers every accepted request one
// cycle later unless the row asks it to hold the response back.
module tb_pc_fetch_unit;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic              clk;
    logic              reset;
    logic              redirect_valid;
    logic              pc_input_sel;
    logic [XLEN-1:0]   alu_result;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_rsp_valid;
    logic [XLEN-1:0]   imem_rsp_data;
    logic              if_valid;
    logic              if_ready;
    logic [XLEN-1:0]   if_instr;
    logic [XLEN-1:0]   if_pc;
    logic              fetch_misaligned;

    typedef struct {
        logic          rst;
        logic          redir;
        logic          sel;
        logic [31:0]   alu;
        logic          req_ready;
        logic          ifr;
        logic          rsp_hold;
        logic          e_req_valid;
        logic [31:0]   e_req_addr;
        logic          e_if_valid;
        logic [31:0]   e_if_pc;
        logic          e_mis;
    } vec_t;

    vec_t          vecs[$];
    int            check_count;
    int            error_count;
    logic          pending;
    logic [31:0]   pending_addr;

    pc_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .redirect_valid   (redirect_valid),
        .pc_input_sel     (pc_input_sel),
        .alu_result       (alu_result),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .if_valid         (if_valid),
        .if_ready         (if_ready),
        .if_instr         (if_instr),
        .if_pc            (if_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the run ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    // Memory contents: an address-dependent word so if_instr can be tied to if_pc.
    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return addr ^ 32'h5A5A_C3C3;
    endfunction

    function automatic void add_vec(input logic rst, input logic redir, input logic sel,
                                    input logic [31:0] alu, input logic rdy, input logic ifr,
                                    input logic hold, input logic erv, input logic [31:0] eaddr,
                                    input logic eiv, input logic [31:0] epc, input logic emis);
        vec_t v;
        v.rst = rst;   v.redir = redir;  v.sel = sel;     v.alu = alu;
        v.req_ready = rdy; v.ifr = ifr;  v.rsp_hold = hold;
        v.e_req_valid = erv; v.e_req_addr = eaddr;
        v.e_if_valid = eiv;  v.e_if_pc = epc;  v.e_mis = emis;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s (vec %0d): got %h, expected %h", name, idx, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        reset          = v.rst;
        redirect_valid = v.redir;
        pc_input_sel   = v.sel;
        alu_result     = v.alu;
        imem_req_ready = v.req_ready;
        if_ready       = v.ifr;
        imem_rsp_valid = pending && !v.rsp_hold;
        imem_rsp_data  = (pending && !v.rsp_hold) ? instr_of(pending_addr) : 32'hDEAD_BEEF;
    endtask

    initial begin
        check_count    = 0;
        error_count    = 0;
        pending        = 1'b0;
        pending_addr   = '0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        pc_input_sel   = 1'b0;
        alu_result     = '0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready       = 1'b1;

        //      rst rd sel alu            rdy ifr hold  erv eaddr          eiv epc            emis
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h100,        0, 32'h0,         0); // c0
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c1
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h104,        1, 32'h100,       0); // c2
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c3
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h108,        1, 32'h104,       0); // c4
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c5
        for (int k = 0; k < 5; k++)                                                          // c6..c10 backpressure
            add_vec(0, 0, 0, 32'h0,     1, 0, 0,    0, 32'h0,          1, 32'h108,       0);
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h10C,        1, 32'h108,       0); // c11 resume
        add_vec(0, 1, 1, 32'h200,       1, 1, 1,    0, 32'h0,          0, 32'h0,         0); // c12 redirect in WAIT
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c13 stale rsp dropped
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h200,        0, 32'h0,         0); // c14
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c15
        add_vec(0, 1, 0, 32'h999,       1, 1, 0,    1, 32'h204,        1, 32'h200,       0); // c16 PC_PLUS_4 no-op
        add_vec(0, 1, 1, 32'h300,       1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c17 redirect with rsp
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h300,        0, 32'h0,         0); // c18
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c19
        add_vec(0, 1, 1, 32'h400,       1, 1, 0,    1, 32'h304,        1, 32'h300,       0); // c20 redirect on accept
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c21 killed rsp
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h400,        0, 32'h0,         0); // c22
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c23
        add_vec(0, 0, 0, 32'h0,         0, 1, 0,    1, 32'h404,        1, 32'h400,       0); // c24 memory stalls
        add_vec(0, 1, 1, 32'h500,       0, 1, 0,    1, 32'h404,        0, 32'h0,         0); // c25 abandon request
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h500,        0, 32'h0,         0); // c26
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c27
        add_vec(0, 1, 1, 32'hFFFF_FFFC, 1, 1, 0,    1, 32'h504,        1, 32'h500,       0); // c28
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c29
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'hFFFF_FFFC,  0, 32'h0,         0); // c30
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c31
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h0,          1, 32'hFFFF_FFFC, 0); // c32 wrap
        add_vec(0, 1, 1, 32'h206,       1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c33 misaligned target
`ifdef PC_FETCH_MISALIGN_TRAP_EN
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         1); // c34 halted
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         1); // c35
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         1); // c36
        add_vec(1, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         1); // c37 reset
`else
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h204,        0, 32'h0,         0); // c34 aligned down
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c35
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h208,        1, 32'h204,       0); // c36
        add_vec(1, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c37 reset, rsp in flight
`endif
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h100,        0, 32'h0,         0); // c38
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    0, 32'h0,          0, 32'h0,         0); // c39
        add_vec(0, 0, 0, 32'h0,         1, 1, 0,    1, 32'h104,        1, 32'h100,       0); // c40

        // Hold reset for a couple of edges and check the cleared state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_if_valid",   -1, 32'(if_valid),         32'h0);
        checkOutput("reset_if_pc",      -1, if_pc,                 32'h0);
        checkOutput("reset_if_instr",   -1, if_instr,              32'h0);
        checkOutput("reset_req_valid",  -1, 32'(imem_req_valid),   32'h0);
        checkOutput("reset_misaligned", -1, 32'(fetch_misaligned), 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            applyStimulus(vecs[i]);
            #1;
            checkOutput("req_valid", i, 32'(imem_req_valid), 32'(vecs[i].e_req_valid));
            if (vecs[i].e_req_valid)
                checkOutput("req_addr", i, imem_req_addr, vecs[i].e_req_addr);
            checkOutput("if_valid", i, 32'(if_valid), 32'(vecs[i].e_if_valid));
            if (vecs[i].e_if_valid) begin
                checkOutput("if_pc",    i, if_pc,    vecs[i].e_if_pc);
                checkOutput("if_instr", i, if_instr, instr_of(vecs[i].e_if_pc));
            end
            checkOutput("misaligned", i, 32'(fetch_misaligned), 32'(vecs[i].e_mis));
            // Memory model bookkeeping for the response due next cycle.
            if (imem_rsp_valid)
                pending = 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                pending      = 1'b1;
                pending_addr = imem_req_addr;
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
